// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one serial transmitter among byte-stream requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TIMEOUT = 1024,
  localparam int GW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1),
  localparam int IW = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          evt_timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d, winner;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic tx_valid_q, tx_valid_d, evt_timeout_q, evt_timeout_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic any_valid, open, take, stall;
  // grantee may hand over a byte only when the holding register is empty
  assign open = (state_q == GRANT) && !tx_valid_q;
  assign take = open && req_valid[grant_id_q];
  assign stall = open && !req_valid[grant_id_q];
  assign req_ready = open ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant_id = grant_id_q;
  assign busy = (state_q == GRANT) || tx_valid_q;
  assign evt_timeout = evt_timeout_q;
  // round-robin scan starting just after the previous grantee
  always_comb begin
    winner = grant_id_q;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_valid && req_valid[(int'(grant_id_q) + k) % NUM_REQ]) begin
        winner = GW'((int'(grant_id_q) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end
  // next-state: arbitration, byte capture, burst cap and stall timeout
  always_comb begin
    state_d = state_q;
    grant_id_d = grant_id_q;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q && !tx_ready;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d = idle_cnt_q;
    evt_timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (any_valid) begin
        state_d = GRANT;
        grant_id_d = winner;
        burst_cnt_d = '0;
        idle_cnt_d = '0;
      end
    end else if (take) begin
      tx_data_d = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
      tx_valid_d = 1'b1;
      burst_cnt_d = burst_cnt_q + 1'b1;
      idle_cnt_d = '0;
      if (req_last[grant_id_q] || burst_cnt_q == BW'(MAX_BURST - 1)) state_d = IDLE;
    end else if (stall) begin
      if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) begin
        state_d = IDLE;
        evt_timeout_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end
  // state register; reset parks the pointer on the last requester so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_id_q <= GW'(NUM_REQ - 1);
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      burst_cnt_q <= '0;
      idle_cnt_q <= '0;
      evt_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_id_q <= grant_id_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      evt_timeout_q <= evt_timeout_d;
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one serial transmitter among NUM_REQ byte-stream requesters. Arbitration is round-robin and packet-granular: a grant is held until the requester's last byte, a burst cap, or an idle timeout. Each requester presents a valid/ready/last byte stream. The block drives the transmitter's data/valid inputs from a one-entry holding register and observes its ready output.

Parameters:
NUM_REQ, 4, number of requesters (>= 2)
DATA_WIDTH, 8, byte width; must match the transmitter
MAX_BURST, 16, max bytes per grant before forced release (>= 1)
IDLE_TIMEOUT, 1024, cycles a granted requester may stall (no valid) before release (>= 1)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
req_data  input  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
req_valid  input  NUM_REQ  requester byte valid
req_last  input  NUM_REQ  byte is the final byte of the packet
req_ready  output  NUM_REQ  byte accepted from requester i this cycle when req_valid[i] is also high
tx_data  output  DATA_WIDTH  byte to transmitter
tx_valid  output  1  holding register full
tx_ready  input  1  transmitter ready; transfer when tx_valid && tx_ready
grant_id  output  $clog2(NUM_REQ)  current or last granted requester
busy  output  1  state==GRANT or tx_valid
evt_timeout  output  1  one-cycle pulse on a timeout release

Behaviour:
- Reset (rstn=0 at posedge clk): state=IDLE, tx_valid=0, tx_data=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), burst_cnt=0, idle_cnt=0, evt_timeout=0. req_ready=0 and busy=0 in the following cycle. Reset mid-packet drops the grant and any held byte; it does not touch a byte already inside the transmitter.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, select the first set bit scanning from grant_id+1 upward, modulo NUM_REQ.
  - At the next edge: grant_id<=winner, state<=GRANT, burst_cnt<=0, idle_cnt<=0.
  - req_ready=0 in IDLE.
- GRANT:
  - req_ready[i] = (i==grant_id) && !tx_valid. This is combinational from registers only; there is no combinational path from req_valid to req_ready.
  - Capture (req_valid[g] && req_ready[g]): tx_data<=byte, tx_valid<=1, burst_cnt<=burst_cnt+1, idle_cnt<=0.
  - Release on capture: if req_last[g]=1 or burst_cnt+1==MAX_BURST, state<=IDLE at that same edge. grant_id keeps its value for the round-robin pointer.
  - Stall counting: while req_ready[g]=1 and req_valid[g]=0, idle_cnt increments.
  - Timeout: when idle_cnt==IDLE_TIMEOUT-1 and still no valid, state<=IDLE and evt_timeout=1 for one cycle. A requester released mid-packet re-arbitrates normally; the packet is not flushed.
  - Cycles with tx_valid=1 (waiting on the transmitter) do not count as stall.
- Holding register:
  - tx_valid clears on an edge where tx_valid && tx_ready.
  - Capture and drain never coincide, because req_ready requires !tx_valid.
  - tx_data is stable while tx_valid=1.
- IDLE may arbitrate and enter GRANT while tx_valid=1. The new grantee's first req_ready then waits for the drain.
- Latency from an idle block: req_valid at cycle 0 → grant at edge 1 → req_ready high cycle 1 → tx_valid high cycle 2. Zero-cycle path from req_valid to tx_valid: none.
- Throughput: at most one byte per 2 cycles (capture, drain), far above any UART bit rate.
- Simultaneous requests: resolved by the round-robin scan; ties are impossible.
- A request dropped before the grant takes effect costs one GRANT cycle and an idle count. The timeout then releases it.
- Counter widths:
  - burst_cnt: $clog2(MAX_BURST+1).
  - idle_cnt: $clog2(IDLE_TIMEOUT+1).
  - Neither counter ever wraps.
- busy = (state==GRANT) || tx_valid.

Test Plan:
1. Single requester: after reset, req 0 sends 3-byte packet 0xA5,0x5A,0xFF (last on 0xFF), tx_ready tied 1 → tx_valid first high 2 cycles after req_valid. Bytes appear in order. Return to IDLE the edge 0xFF is captured. busy low one cycle after the drain.
2. Round-robin: reqs 0,1,2,3 all valid with 1-byte packets → grant_id sequence 0,1,2,3,0. Then after grant_id=1, only reqs 0 and 3 valid → 3 before 0.
3. Burst cap: MAX_BURST=4, req 2 streams 10 bytes with last on byte 10 and req 1 also valid → order is req 2 bytes 1–4, req 1 packet, req 2 bytes 5–8, and so on.
4. Backpressure: tx_ready held 0 for 50 cycles after capture → tx_valid and tx_data stable, req_ready=0, no timeout even with IDLE_TIMEOUT=8.
5. Timeout: IDLE_TIMEOUT=8, req 1 sends one non-last byte then drops valid while req 3 valid → evt_timeout pulses exactly 8 stall cycles after req_ready reasserts, and grant moves to 3.
6. Reset mid-packet: rstn low for 1 cycle while tx_valid=1 in GRANT → next cycle tx_valid=0, req_ready=0, busy=0, grant_id=NUM_REQ-1. The next arbitration picks requester 0 first.
